// File: rtl/exe_pkg.sv
// Shared types and constants for the execution-unit scheduler and its ALU.
package exe_pkg;

    // Opcodes accepted from either requester.
    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_OR      = 3'b011,
        OP_XOR     = 3'b100,
        OP_U2GRAY  = 3'b101,
        OP_GRAY2U2 = 3'b110,
        OP_ILL     = 3'b111
    } op_e;

    // Bit positions inside the 4-bit {Z,N,V,E} flag vector.
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_V = 1;
    localparam int FLG_E = 0;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/exe_alu.sv
// Combinational execution unit: arithmetic, logic and two's-complement/Gray conversions.
module exe_alu
    import exe_pkg::*;
#(
    parameter int BITS = 8
) (
    input  op_e             i_op,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_result,
    output logic [3:0]      o_flags
);

    logic [BITS-1:0] result;
    logic [BITS-1:0] gray_dec;
    logic            par;
    logic            ovf;
    logic            err;

    // Compute result, then derive flags from it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        result   = '0;
        gray_dec = '0;
        par      = 1'b0;
        ovf      = 1'b0;
        err      = 1'b0;

        // Gray decode: each binary bit is the running XOR of the Gray bits from the MSB down.
        for (int i = BITS - 1; i >= 0; i--) begin
            par         = par ^ i_a[i];
            gray_dec[i] = par;
        end

        case (i_op)
            OP_ADD: begin
                result = i_a + i_b;
                ovf    = (i_a[BITS-1] == i_b[BITS-1]) && (result[BITS-1] != i_a[BITS-1]);
            end
            OP_SUB: begin
                result = i_a - i_b;
                ovf    = (i_a[BITS-1] != i_b[BITS-1]) && (result[BITS-1] != i_a[BITS-1]);
            end
            OP_AND: result = i_a & i_b;
            OP_OR:  result = i_a | i_b;
            OP_XOR: result = i_a ^ i_b;
            OP_U2GRAY: begin
                // Negative inputs have no Gray encoding in this scheme: flag them.
                if (i_a[BITS-1]) begin
                    err = 1'b1;
                end else begin
                    result = i_a ^ (i_a >> 1);
                end
            end
            OP_GRAY2U2: result = gray_dec;
            default:    err    = 1'b1;
        endcase

        o_result        = result;
        o_flags         = '0;
        o_flags[FLG_Z]  = (result == '0);
        o_flags[FLG_N]  = result[BITS-1];
        o_flags[FLG_V]  = ovf;
        o_flags[FLG_E]  = err;
    end

endmodule

// File: rtl/exe_unit_scheduler.sv
// Round-robin scheduler sharing one exe_alu between two valid/ready requesters.
module exe_unit_scheduler
    import exe_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rsn,
    input  logic [1:0]      i_req_valid,
    output logic [1:0]      o_req_ready,
    input  logic [2:0]      i_op_0,
    input  logic [2:0]      i_op_1,
    input  logic [BITS-1:0] i_argA_0,
    input  logic [BITS-1:0] i_argA_1,
    input  logic [BITS-1:0] i_argB_0,
    input  logic [BITS-1:0] i_argB_1,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [BITS-1:0] o_result,
    output logic [3:0]      o_flags
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    op_e             op_q, op_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic            id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [BITS-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    logic            grant_id;
    logic [1:0]      req_ready;
    logic [BITS-1:0] alu_result;
    logic [3:0]      alu_flags;

    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign grant_id = i_req_valid[1] & (~i_req_valid[0] | rr_q);

    exe_alu #(
        .BITS (BITS)
    ) u_alu (
        .i_op     (op_q),
        .i_a      (a_q),
        .i_b      (b_q),
        .o_result (alu_result),
        .o_flags  (alu_flags)
    );

    // Next-state logic: arbitration and operand capture in IDLE, timed EXEC, response hold in RESP.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        result_d    = result_q;
        flags_d     = flags_q;
        req_ready   = 2'b00;

        case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    req_ready[grant_id] = 1'b1;
                    op_d    = op_e'(grant_id ? i_op_1   : i_op_0);
                    a_d     = grant_id ? i_argA_1 : i_argA_0;
                    b_d     = grant_id ? i_argB_1 : i_argB_0;
                    id_d    = grant_id;
                    rr_d    = ~grant_id;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d    = alu_result;
                    flags_d     = alu_flags;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign o_req_ready = req_ready;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_result    = result_q;
    assign o_flags     = flags_q;

endmodule

// File: tb/tb_exe_unit_scheduler.sv
// Self-checking bench for exe_unit_scheduler with a behavioural reference model.
module tb_exe_unit_scheduler;

    localparam int BITS = 8;
    localparam int EXC  = 3;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2:0]      op0, op1;
    logic [7:0]      a0, a1, b0, b1;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [7:0]      result;
    logic [3:0]      flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic rr_m  = 1'b0;

    exe_unit_scheduler #(
        .BITS        (BITS),
        .EXEC_CYCLES (EXC)
    ) dut (
        .i_clk       (clk),
        .i_rsn       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_op_0      (op0),
        .i_op_1      (op1),
        .i_argA_0    (a0),
        .i_argA_1    (a1),
        .i_argB_0    (b0),
        .i_argB_1    (b1),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_result    (result),
        .o_flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic on unsigned/signed values.
    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] r, output logic [3:0] f);
        int ia, ib, sa, sb, s, res;
        bit v, e;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        v = 1'b0;
        e = 1'b0;
        res = 0;
        case (op)
            3'd0: begin res = (ia + ib) % 256;       s = sa + sb; v = (s > 127) || (s < -128); end
            3'd1: begin res = (ia - ib + 256) % 256; s = sa - sb; v = (s > 127) || (s < -128); end
            3'd2: res = ia & ib;
            3'd3: res = ia | ib;
            3'd4: res = ia ^ ib;
            3'd5: begin
                if (ia >= 128) e = 1'b1;
                else           res = ia ^ (ia / 2);
            end
            3'd6: for (int k = 0; k < 8; k++) res = res ^ (ia >> k);
            default: e = 1'b1;
        endcase
        r = res[7:0];
        f = {res == 0, res >= 128, v, e};
    endfunction

    // Present a request, follow it through accept/EXEC/RESP and check every phase.
    task automatic run_txn(input string tag, input logic [1:0] valid,
                           input logic [2:0] o_0, input logic [7:0] a_0, input logic [7:0] b_0,
                           input logic [2:0] o_1, input logic [7:0] a_1, input logic [7:0] b_1,
                           input logic [1:0] hold, input int stall, input bit drop);
        logic       g;
        logic [7:0] er;
        logic [3:0] ef;
        req_valid = valid;
        op0 = o_0; a0 = a_0; b0 = b_0;
        op1 = o_1; a1 = a_1; b1 = b_1;
        #1;
        g = (valid == 2'b11) ? rr_m : valid[1];
        if (g) ref_model(o_1, a_1, b_1, er, ef);
        else   ref_model(o_0, a_0, b_0, er, ef);
        chk({tag, "/ready"}, 32'(req_ready), g ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        rr_m = ~g;
        req_valid = hold;
        op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        for (int k = 0; k < EXC; k++) begin
            chk({tag, "/exec_valid"}, 32'(rsp_valid), 32'h0);
            chk({tag, "/exec_ready"}, 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "/rsp_id"},    32'(rsp_id),    32'(g));
        chk({tag, "/result"},    32'(result),    32'(er));
        chk({tag, "/flags"},     32'(flags),     32'(ef));
        chk({tag, "/resp_ready"}, 32'(req_ready), 32'h0);
        for (int s = 0; s < stall; s++) begin
            a0 = 8'($urandom); a1 = 8'($urandom);
            @(posedge clk); #1;
            chk({tag, "/hold_valid"},  32'(rsp_valid), 32'h1);
            chk({tag, "/hold_result"}, 32'(result),    32'(er));
            chk({tag, "/hold_flags"},  32'(flags),     32'(ef));
            chk({tag, "/hold_id"},     32'(rsp_id),    32'(g));
            chk({tag, "/hold_ready"},  32'(req_ready), 32'h0);
        end
        if (drop) req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "/rsp_clear"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;

        // Reset state
        #12;
        chk("rst/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst/req_ready", 32'(req_ready), 32'h0);
        chk("rst/rsp_id",    32'(rsp_id),    32'h0);
        chk("rst/result",    32'(result),    32'h0);
        chk("rst/flags",     32'(flags),     32'h0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Both requesters valid continuously: ids alternate 0,1,0,1, Gray 0x07 -> 0x05
        for (int t = 0; t < 4; t++) begin
            run_txn("both", 2'b11, 3'b110, 8'h07, 8'h00, 3'b110, 8'h07, 8'h00, 2'b11, 0, 1'b0);
            chk("both/id_seq", 32'(rsp_id), 32'(t % 2));
            chk("both/val",    32'(result), 32'h05);
        end

        // Requester 0 alone, U2->Gray of 0x05
        run_txn("u2g_pos", 2'b01, 3'b101, 8'h05, 8'h00, 3'b000, 8'h00, 8'h00, 2'b00, 0, 1'b0);
        chk("u2g_pos/val",   32'(result), 32'h07);
        chk("u2g_pos/flags", 32'(flags),  32'h0);

        // Requester 1 alone, negative input to U2->Gray
        run_txn("u2g_neg", 2'b10, 3'b000, 8'h00, 8'h00, 3'b101, 8'h85, 8'h00, 2'b00, 0, 1'b0);
        chk("u2g_neg/flags", 32'(flags), 32'h9);

        // Signed overflow on add and sub
        run_txn("add_ovf", 2'b01, 3'b000, 8'h7F, 8'h01, 3'b000, 8'h00, 8'h00, 2'b00, 0, 1'b0);
        chk("add_ovf/val",   32'(result), 32'h80);
        chk("add_ovf/flags", 32'(flags),  32'h6);
        run_txn("sub_ovf", 2'b01, 3'b001, 8'h80, 8'h01, 3'b000, 8'h00, 8'h00, 2'b00, 0, 1'b0);
        chk("sub_ovf/val",   32'(result), 32'h7F);
        chk("sub_ovf/flags", 32'(flags),  32'h2);

        // Stalled consumer with requester 1 waiting; it gets the first IDLE cycle
        run_txn("stall", 2'b01, 3'b010, 8'hF0, 8'h3C, 3'b011, 8'h0F, 8'h30, 2'b10, 5, 1'b0);
        run_txn("after", 2'b10, 3'b000, 8'h00, 8'h00, 3'b011, 8'h0F, 8'h30, 2'b00, 0, 1'b0);
        chk("after/val", 32'(result), 32'h3F);

        // Requester drops valid before reaching IDLE: no transaction starts
        run_txn("drop", 2'b01, 3'b111, 8'h12, 8'h34, 3'b000, 8'h00, 8'h00, 2'b10, 2, 1'b1);
        chk("drop/ill_flags", 32'(flags), 32'h9);
        for (int c = 0; c < 4; c++) begin
            chk("drop/no_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            chk("drop/no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Reset in the middle of EXEC discards the transaction and the pointer
        req_valid = 2'b01; op0 = 3'b000; a0 = 8'h11; b0 = 8'h22;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst/rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst/req_ready", 32'(req_ready), 32'h0);
        chk("midrst/result",    32'(result),    32'h0);
        chk("midrst/flags",     32'(flags),     32'h0);
        chk("midrst/rsp_id",    32'(rsp_id),    32'h0);
        #2 rst_n = 1'b1;
        rr_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("midrst/quiet", 32'(rsp_valid), 32'h0);
        end
        run_txn("ptr0", 2'b11, 3'b100, 8'hAA, 8'h0F, 3'b100, 8'h55, 8'hFF, 2'b00, 0, 1'b0);
        chk("ptr0/id", 32'(rsp_id), 32'h0);

        // Randomized traffic against the model
        for (int t = 0; t < 24; t++) begin
            run_txn("rand", 2'($urandom_range(1, 3)),
                    3'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), 8'($urandom), 8'($urandom),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
